// File: rtl/flop_force_pkg.sv
// Shared types and helpers for the preset/clear force controller.
package flop_force_pkg;

    // Command encoding on cmd_op
    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_CLEAR   = 2'b01,
        OP_PRESET  = 2'b10,
        OP_RELEASE = 2'b11
    } op_e;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ASSERT = 2'b01,
        ST_CHECK  = 2'b10,
        ST_SETTLE = 2'b11
    } state_e;

    // Width of the shared hold/settle counter: large enough for the longer wait
    function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned settle);
        int unsigned m;
        m = (hold > settle) ? hold : settle;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/force_hold_counter.sv
// Loadable down-counter with zero flag; times both the force hold and the release settle.
module force_hold_counter #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Load has priority over decrement; decrement saturates at zero
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/flop_force_ctrl.sv
// Command-driven driver for the active-low preset/clear pins of a flop bank,
// with timed hold, readback check and release settle.
module flop_force_ctrl
    import flop_force_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned HOLD_CYCLES   = 4,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    output logic [WIDTH-1:0] clear_n,
    output logic [WIDTH-1:0] preset_n,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] forced,
    output logic             done,
    output logic             err
);

    localparam int unsigned      CNT_W       = cnt_width(HOLD_CYCLES, SETTLE_CYCLES);
    // Counter is loaded on the accept edge, so it starts one below the wait length
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] clear_n_q, clear_n_d;
    logic [WIDTH-1:0] preset_n_q, preset_n_d;
    logic [WIDTH-1:0] forced_q, forced_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    op_e              op_in;
    logic             accept;
    logic             empty_cmd;
    logic [WIDTH-1:0] apply_bit;
    logic [WIDTH-1:0] bad_bit;
    logic             mismatch;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;

    assign op_in     = op_e'(cmd_op);
    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    // NOP or empty mask: nothing to drive, just acknowledge on the next edge
    assign empty_cmd = (op_in == OP_NOP) || (cmd_mask == '0);

    // Per-bit pin update: a masked bit takes the new drive, others keep theirs.
    // Clear and preset are never both low since each op sets exactly one of them.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign apply_bit[gi]  = accept && cmd_mask[gi] && (op_in != OP_NOP);
            assign clear_n_d[gi]  = apply_bit[gi] ? (op_in != OP_CLEAR)   : clear_n_q[gi];
            assign preset_n_d[gi] = apply_bit[gi] ? (op_in != OP_PRESET)  : preset_n_q[gi];
            assign forced_d[gi]   = apply_bit[gi] ? (op_in != OP_RELEASE) : forced_q[gi];
            // Expected readback is 1 only for PRESET; unmasked bits never flag
            assign bad_bit[gi]    = mask_q[gi] && (q_in[gi] != (op_q == OP_PRESET));
        end
    endgenerate

    assign mismatch = |bad_bit;

    // Command capture: a NOP keeps an empty mask so its check can never flag
    assign op_d   = accept ? op_in : op_q;
    assign mask_d = accept ? ((op_in == OP_NOP) ? '0 : cmd_mask) : mask_q;

    force_hold_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // State, capture and output registers; reset drops all forces and pending pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_NOP;
            mask_q     <= '0;
            clear_n_q  <= '1;
            preset_n_q <= '1;
            forced_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            mask_q     <= mask_d;
            clear_n_q  <= clear_n_d;
            preset_n_q <= preset_n_d;
            forced_q   <= forced_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (empty_cmd) begin
                        state_d = ST_CHECK;
                    end else if (op_in == OP_RELEASE) begin
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_ASSERT;
                    end
                end
            end
            ST_ASSERT: begin
                if (cnt_zero) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
            end
            ST_SETTLE: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output/control logic: counter control and next completion pulses
    always_comb begin
        cnt_load     = accept;
        cnt_load_val = (op_in == OP_RELEASE) ? SETTLE_LOAD : HOLD_LOAD;
        cnt_dec      = (state_q == ST_ASSERT) || (state_q == ST_SETTLE);
        done_d       = (state_q == ST_CHECK) || ((state_q == ST_SETTLE) && cnt_zero);
        err_d        = (state_q == ST_CHECK) && mismatch;
    end

    assign clear_n  = clear_n_q;
    assign preset_n = preset_n_q;
    assign forced   = forced_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_flop_force_ctrl.sv
// Directed testbench for flop_force_ctrl with a behavioural preset/clear flop bank.
module tb_flop_force_ctrl;

    localparam logic [1:0] NOP     = 2'b00;
    localparam logic [1:0] CLEAR   = 2'b01;
    localparam logic [1:0] PRESET  = 2'b10;
    localparam logic [1:0] RELEASE = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_mask = 8'h00;
    logic [7:0] clear_n;
    logic [7:0] preset_n;
    logic [7:0] q_in;
    logic [7:0] forced;
    logic       done;
    logic       err;

    logic [7:0] bank = 8'h00;
    logic [7:0] stuck_one = 8'h00;
    logic       inv_en = 1'b0;
    int         acc_cnt = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    flop_force_ctrl #(
        .WIDTH         (8),
        .HOLD_CYCLES   (4),
        .SETTLE_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_mask  (cmd_mask),
        .clear_n   (clear_n),
        .preset_n  (preset_n),
        .q_in      (q_in),
        .forced    (forced),
        .done      (done),
        .err       (err)
    );

    // Flop bank: asynchronous clear/preset, value held otherwise
    always @(clear_n or preset_n) begin
        for (int i = 0; i < 8; i++) begin
            if (clear_n[i] === 1'b0) bank[i] = 1'b0;
            else if (preset_n[i] === 1'b0) bank[i] = 1'b1;
        end
    end
    assign q_in = bank | stuck_one;

    // Accepted-command counter
    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) acc_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Clear and preset must never be low together on any bit
    always @(negedge clk) begin
        if (inv_en) check("never_both_low", {24'h0, clear_n | preset_n}, 32'hFF);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command, wait for acceptance; returns just after the accept edge
    task automatic issue(input logic [1:0] op, input logic [7:0] mask, input bit hold_valid);
        int n;
        cmd_op = op;
        cmd_mask = mask;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        if (!cmd_ready) check("ready_timeout", 0, 1);
        step();
        $display("[TB] accept op=%0d mask=%02h t=%0t", op, mask, $time);
        if (!hold_valid) cmd_valid = 1'b0;
    endtask

    // Count edges after the accept edge until done is seen
    task automatic wait_done(output int lat, output logic e);
        int k;
        k = 0;
        while (!done && k < 20) begin
            step();
            k++;
        end
        if (!done) check("done_timeout", 0, 1);
        lat = k;
        e = err;
        $display("[TB] done after %0d edges err=%0b", lat, e);
    endtask

    initial begin
        int   lat;
        logic e;
        logic any_pulse;

        // Reset then idle
        step();
        step();
        check("rst_ready", cmd_ready, 0);
        check("rst_clear_n", clear_n, 8'hFF);
        check("rst_preset_n", preset_n, 8'hFF);
        check("rst_forced", forced, 8'h00);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        inv_en = 1'b1;
        step();
        check("idle_ready", cmd_ready, 1);
        check("idle_done", done, 0);

        // CLEAR 0F, good readback
        issue(CLEAR, 8'h0F, 0);
        check("clr_clear_n", clear_n, 8'hF0);
        check("clr_preset_n", preset_n, 8'hFF);
        check("clr_forced", forced, 8'h0F);
        check("clr_busy", cmd_ready, 0);
        wait_done(lat, e);
        check("clr_lat", lat, 5);
        check("clr_err", e, 0);
        check("clr_ready_at_done", cmd_ready, 1);

        // PRESET 03 over cleared bits: lines swap on bits 0-1, bits 2-3 stay cleared
        issue(PRESET, 8'h03, 0);
        check("pre_clear_n", clear_n, 8'hF3);
        check("pre_preset_n", preset_n, 8'hFC);
        check("pre_forced", forced, 8'h0F);
        wait_done(lat, e);
        check("pre_lat", lat, 5);
        check("pre_err", e, 0);

        // Stuck-at-1 on bit 2 while clearing it
        stuck_one = 8'h04;
        issue(CLEAR, 8'h04, 0);
        wait_done(lat, e);
        check("stuck_lat", lat, 5);
        check("stuck_err", e, 1);
        step();
        check("stuck_err_pulse", err, 0);
        check("stuck_done_pulse", done, 0);
        stuck_one = 8'h00;

        // RELEASE all with cmd_valid held high
        issue(RELEASE, 8'hFF, 1);
        check("rel_clear_n", clear_n, 8'hFF);
        check("rel_preset_n", preset_n, 8'hFF);
        check("rel_forced", forced, 8'h00);
        wait_done(lat, e);
        check("rel_lat", lat, 2);
        check("rel_err", e, 0);
        check("rel_ready", cmd_ready, 1);
        check("rel_no_dup", acc_cnt, 4);

        // NOP accepted on the very next edge, valid still high
        cmd_op = NOP;
        cmd_mask = 8'h00;
        step();
        cmd_valid = 1'b0;
        check("nop_busy", cmd_ready, 0);
        check("nop_done_early", done, 0);
        wait_done(lat, e);
        check("nop_lat", lat, 1);
        check("nop_err", e, 0);

        // CLEAR with empty mask behaves like NOP
        issue(CLEAR, 8'h00, 0);
        check("empty_clear_n", clear_n, 8'hFF);
        check("empty_forced", forced, 8'h00);
        wait_done(lat, e);
        check("empty_lat", lat, 1);
        check("empty_err", e, 0);

        // Reset two cycles into a PRESET hold
        issue(PRESET, 8'hAA, 0);
        check("mid_preset_n", preset_n, 8'h55);
        step();
        step();
        rst = 1'b1;
        step();
        check("mid_clear_n", clear_n, 8'hFF);
        check("mid_preset_n_rel", preset_n, 8'hFF);
        check("mid_forced", forced, 8'h00);
        check("mid_done", done, 0);
        rst = 1'b0;
        any_pulse = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            any_pulse = any_pulse | done | err;
        end
        check("mid_no_pulse", any_pulse, 0);
        check("mid_ready", cmd_ready, 1);
        check("total_accepts", acc_cnt, 7);

        inv_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
